// File: rtl/prog_mem_arbiter.sv
// prog_mem_arbiter: shares the single program memory between the instruction
// fetch sequencer (F, read only) and the loader/debug port (L, read/write).
// Each grant runs IDLE -> ISSUE -> [WAIT x MEM_LAT] -> DONE, and the owner gets
// a one-cycle ack in DONE.
// Optional macro PROG_MEM_ARB_RR_EN: ties are broken round-robin instead of
// by F priority with the starvation override.
module prog_mem_arbiter #(
  parameter int unsigned ADDR_W     = 8,
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned MEM_LAT    = 1,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  output logic              f_ack,
  output logic [DATA_W-1:0] f_data,
  input  logic              l_req,
  input  logic              l_we,
  input  logic [ADDR_W-1:0] l_addr,
  input  logic [DATA_W-1:0] l_wdata,
  output logic              l_ack,
  output logic [DATA_W-1:0] l_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              mem_sel,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  localparam logic [3:0] LAT_LAST = 4'(MEM_LAT - 1);

  state_t              state, state_nx;
  logic                owner;      // 1 = loader owns the current transaction
  logic [ADDR_W-1:0]   addr_q;
  logic                we_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [3:0]          wait_cnt;
  logic                wait_last;
  logic                grant;
  logic                grant_l;
  logic                tie_l;      // L wins when both request

`ifdef PROG_MEM_ARB_RR_EN
  logic last_l;

  assign tie_l = ~last_l;

  // Remember the most recent winner; resets to L so F takes the first tie.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)      last_l <= 1'b1;
    else if (grant) last_l <= grant_l;
  end
`else
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  logic [3:0] starve_cnt;

  assign tie_l = (starve_cnt == STARVE_LIM);

  // Count lost L arbitrations (saturating); an L grant clears the count.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      starve_cnt <= '0;
    else if (grant_l)
      starve_cnt <= '0;
    else if (grant && l_req && starve_cnt != STARVE_LIM)
      starve_cnt <= starve_cnt + 4'd1;
  end
`endif

  assign wait_last = (wait_cnt == LAT_LAST);

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Next state and arbitration; arbitration is only evaluated in IDLE.
  always_comb begin
    state_nx = state;
    grant    = 1'b0;
    grant_l  = 1'b0;
    case (state)
      IDLE: begin
        if (f_req || l_req) begin
          grant    = 1'b1;
          grant_l  = l_req && (!f_req || tie_l);
          state_nx = ISSUE;
        end
      end
      ISSUE:   state_nx = we_q ? DONE : WAIT;
      WAIT:    if (wait_last) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Latch the granted request, time the memory latency, capture read data.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      owner    <= 1'b0;
      addr_q   <= '0;
      we_q     <= 1'b0;
      wdata_q  <= '0;
      wait_cnt <= '0;
      f_data   <= '0;
      l_rdata  <= '0;
    end else begin
      if (grant) begin
        owner   <= grant_l;
        addr_q  <= grant_l ? l_addr : f_addr;
        we_q    <= grant_l && l_we;
        wdata_q <= l_wdata;
      end
      if (state == ISSUE)
        wait_cnt <= '0;
      else if (state == WAIT)
        wait_cnt <= wait_cnt + 4'd1;
      if (state == WAIT && wait_last) begin
        if (owner) l_rdata <= mem_rdata;
        else       f_data  <= mem_rdata;
      end
    end
  end

  assign busy      = (state != IDLE);
  assign mem_en    = (state == ISSUE);
  assign mem_we    = mem_en && we_q;
  assign mem_addr  = mem_en ? addr_q : '0;
  assign mem_wdata = mem_we ? wdata_q : '0;
  assign mem_sel   = busy && owner;
  assign f_ack     = (state == DONE) && !owner;
  assign l_ack     = (state == DONE) && owner;

endmodule

// File: tb/tb_prog_mem_arbiter.sv
// Bench for prog_mem_arbiter (MEM_LAT=3, STARVE_MAX=2). A transaction-level
// reference predicts every output each cycle from grant time and access type.
module tb_prog_mem_arbiter;
  localparam int unsigned AW   = 8;
  localparam int unsigned DW   = 8;
  localparam int          LAT  = 3;
  localparam int          SMAX = 2;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          f_req, l_req, l_we;
  logic [AW-1:0] f_addr, l_addr;
  logic [DW-1:0] l_wdata;
  logic          f_ack, l_ack, mem_en, mem_we, mem_sel, busy;
  logic [DW-1:0] f_data, l_rdata, mem_wdata, mem_rdata;
  logic [AW-1:0] mem_addr;

  prog_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT), .STARVE_MAX(SMAX)) dut (
    .clock(clock), .reset(reset),
    .f_req(f_req), .f_addr(f_addr), .f_ack(f_ack), .f_data(f_data),
    .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata),
    .l_ack(l_ack), .l_rdata(l_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_sel(mem_sel), .busy(busy)
  );

  always #5 clock = ~clock;

  function automatic logic [7:0] init_val(input logic [7:0] a);
    return a ^ 8'hB5;
  endfunction

  // Memory device: read data is valid only exactly LAT cycles after mem_en.
  bit   [7:0] mem [256];
  bit         wv  [256];
  logic [7:0] raddr;
  int         rcnt;

  always @(posedge clock) begin
    if (!reset && mem_en && mem_we) begin
      mem[mem_addr] <= mem_wdata;
      wv[mem_addr]  <= 1'b1;
    end
  end

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      rcnt  <= 0;
      raddr <= '0;
    end else if (mem_en && !mem_we) begin
      rcnt  <= 1;
      raddr <= mem_addr;
    end else if (rcnt != 0 && rcnt < 16) begin
      rcnt <= rcnt + 1;
    end
  end

  assign mem_rdata = (rcnt == LAT) ? (wv[raddr] ? mem[raddr] : init_val(raddr)) : 8'hEE;

  // Reference model state
  logic [7:0] ref_mem [256];
  int         cyc, t_g, t_len, starve;
  bit         t_act, t_l, t_we, last_l;
  logic [7:0] t_addr, t_wdata, exp_f, exp_l;
  bit         f_acked, l_acked;
  bit         dut_grants[$];
  int         checks, errors;
  bit         f_on, l_on;
  int         f_gap, l_gap, max_gap;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s cycle %0d observed %0h expected %0h", tag, cyc, obs, want);
    end
  endtask

  task automatic chk_zero(input string ph);
    chk({ph, "_f_ack"}, f_ack, 0);     chk({ph, "_f_data"}, f_data, 0);
    chk({ph, "_l_ack"}, l_ack, 0);     chk({ph, "_l_rdata"}, l_rdata, 0);
    chk({ph, "_mem_en"}, mem_en, 0);   chk({ph, "_mem_we"}, mem_we, 0);
    chk({ph, "_mem_addr"}, mem_addr, 0); chk({ph, "_mem_wdata"}, mem_wdata, 0);
    chk({ph, "_mem_sel"}, mem_sel, 0); chk({ph, "_busy"}, busy, 0);
  endtask

  task automatic model_reset();
    t_act = 0; starve = 0; last_l = 1; exp_f = '0; exp_l = '0;
    f_acked = 0; l_acked = 0; cyc = 0;
  endtask

  task automatic arbitrate();
    bit win_l;
    if (f_req || l_req) begin
`ifdef PROG_MEM_ARB_RR_EN
      win_l  = l_req && (!f_req || !last_l);
      last_l = win_l;
`else
      win_l = l_req && (!f_req || starve == SMAX);
      if (win_l) starve = 0;
      else if (l_req && starve < SMAX) starve++;
`endif
      t_act = 1; t_g = cyc; t_l = win_l; t_we = win_l && l_we;
      t_addr = win_l ? l_addr : f_addr; t_wdata = l_wdata;
      t_len = t_we ? 2 : 2 + LAT;
    end
  endtask

  // One clock cycle: check this cycle's outputs, arbitrate if idle, advance.
  task automatic step();
    bit e_en, e_we, e_busy, e_sel, e_fa, e_la;
    int d;
    e_en = 0; e_we = 0; e_busy = 0; e_sel = 0; e_fa = 0; e_la = 0;
    @(negedge clock);
    if (t_act && cyc > t_g + t_len) t_act = 0;
    if (t_act) begin
      d = cyc - t_g;
      e_busy = 1; e_sel = t_l; e_en = (d == 1); e_we = e_en && t_we;
      e_fa = (d == t_len) && !t_l; e_la = (d == t_len) && t_l;
      if (e_we) ref_mem[t_addr] = t_wdata;
      if (e_fa) exp_f = ref_mem[t_addr];
      if (e_la && !t_we) exp_l = ref_mem[t_addr];
    end
    chk("busy", busy, e_busy);     chk("mem_en", mem_en, e_en);
    chk("mem_we", mem_we, e_we);   chk("mem_sel", mem_sel, e_sel);
    chk("f_ack", f_ack, e_fa);     chk("l_ack", l_ack, e_la);
    chk("f_data", f_data, exp_f);  chk("l_rdata", l_rdata, exp_l);
    if (e_en) chk("mem_addr", mem_addr, t_addr);
    if (e_we) chk("mem_wdata", mem_wdata, t_wdata);
    if (mem_en === 1'b1) dut_grants.push_back(mem_sel);
    f_acked = e_fa; l_acked = e_la;
    if (!t_act) arbitrate();
    @(posedge clock);
    #1;
    cyc++;
  endtask

  // Requesters: hold until ack, drop on the ack edge, re-request after a gap.
  task automatic agents();
    if (f_acked) begin f_req = 1'b0; f_gap = $urandom_range(max_gap, 0); end
    if (l_acked) begin l_req = 1'b0; l_gap = $urandom_range(max_gap, 0); end
    if (f_on && !f_req) begin
      if (f_gap == 0) begin f_req = 1'b1; f_addr = 8'($urandom_range(31, 0)); end
      else f_gap--;
    end
    if (l_on && !l_req) begin
      if (l_gap == 0) begin
        l_req = 1'b1; l_we = 1'($urandom_range(1, 0));
        l_addr = 8'($urandom_range(15, 0)); l_wdata = 8'($urandom);
      end else l_gap--;
    end
  endtask

  task automatic run(input int n);
    repeat (n) begin step(); agents(); end
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    model_reset();
  endtask

  initial begin
    f_req = 0; f_addr = '0; l_req = 0; l_we = 0; l_addr = '0; l_wdata = '0;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_val(8'(i));
    f_on = 0; l_on = 0; f_gap = 0; l_gap = 0; max_gap = 0;
    checks = 0; errors = 0;
    model_reset();
    #1 reset = 1'b1;
    @(negedge clock); chk_zero("por");
    @(posedge clock); #1;
    reset = 1'b0;
    model_reset();

    // F read of 0x10: issue in cycle 1, ack in cycle 2+LAT, data 0xA5
    f_req = 1; f_addr = 8'h10;
    run(2 + LAT + 3);
    chk("fetch_a5", f_data, 8'hA5);

    // L write 0x3C to 0x22, then L read back
    l_req = 1; l_we = 1; l_addr = 8'h22; l_wdata = 8'h3C;
    run(4);
    l_req = 1; l_we = 0; l_addr = 8'h22;
    run(2 + LAT + 3);
    chk("load_rd_3c", l_rdata, 8'h3C);

    // Reset during the second WAIT cycle: outputs clear at once, no ack
    f_req = 1; f_addr = 8'h31;
    run(3);
    #2 reset = 1'b1;
    #1 chk_zero("mid_rst");
    f_req = 0;
    @(posedge clock); #1;
    reset = 1'b0;
    model_reset();
    f_req = 1; f_addr = 8'h10;
    run(2 + LAT + 3);

    // F request dropped in the ISSUE cycle still completes, once
    f_req = 1; f_addr = 8'h10;
    run(1);
    f_req = 0;
    run(2 + LAT + 3);
    chk("drop_fdata", f_data, 8'hA5);

    // Both requesters held continuously from a fresh reset
    pulse_reset();
    dut_grants.delete();
    f_on = 1; l_on = 1; max_gap = 0;
    agents();
    run(45);
    chk("grant_count", dut_grants.size() >= 6, 1);
    for (int i = 0; i < 6 && i < dut_grants.size(); i++) begin
`ifdef PROG_MEM_ARB_RR_EN
      chk($sformatf("grant_%0d", i), dut_grants[i], (i % 2) == 1);
`else
      chk($sformatf("grant_%0d", i), dut_grants[i], (i % (SMAX + 1)) == SMAX);
`endif
    end

    // Randomized traffic with gaps, then drain
    max_gap = 2;
    run(400);
    f_on = 0; l_on = 0;
    run(20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
